// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Owns the single write port (Load/DR/Bus) of the 8x16 LC-3 register file.
//   Two requesters share the port: A (execute datapath) and B (load/debug unit).
//   A "clear all" sweep writes 0 to R0..R7 on request and takes priority over A/B.
//
//   Build option: define REGARB_FIXED_PRIO_EN to give A strict priority on ties
//   (B can starve while A is held). Default build uses round-robin tie-break.
//
// Ports
//   Clk, Reset             clock (posedge) and asynchronous active-high reset
//   A_Req/A_DR/A_Data      requester A; held stable until A_Gnt
//   A_Gnt                  combinational grant to A (write accepted at the edge)
//   B_Req/B_DR/B_Data      requester B; same rules as A
//   B_Gnt                  combinational grant to B
//   Clear_Req              level request for a clear-all sweep, sampled in IDLE
//   Clear_Busy             high while the sweep FSM is in CLEAR
//   Clear_Done             registered pulse coincident with the final sweep write
//   Load/DR/Bus            registered register-file write enable, index, data
//
// state  | meaning
// IDLE   | arbitrate A/B, or launch a sweep when Clear_Req is high
// CLEAR  | issue one zero write per cycle to R0..R7, no grants

module regfile_write_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              A_Req,
  input  logic [ADDR_W-1:0] A_DR,
  input  logic [DATA_W-1:0] A_Data,
  output logic              A_Gnt,
  input  logic              B_Req,
  input  logic [ADDR_W-1:0] B_DR,
  input  logic [DATA_W-1:0] B_Data,
  output logic              B_Gnt,
  input  logic              Clear_Req,
  output logic              Clear_Busy,
  output logic              Clear_Done,
  output logic              Load,
  output logic [ADDR_W-1:0] DR,
  output logic [DATA_W-1:0] Bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] CNT_LAST = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              load_q, load_d;
  logic [ADDR_W-1:0] dr_q, dr_d;
  logic [DATA_W-1:0] bus_q, bus_d;
  logic              done_q, done_d;
  logic              a_gnt, b_gnt;
  logic              tie_pick_b;

`ifdef REGARB_FIXED_PRIO_EN
  assign tie_pick_b = 1'b0;
`else
  // 1 = most recent accepted grant went to B. Reset value B makes the first
  // tie after reset go to A.
  logic last_b_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      last_b_q <= 1'b1;
    end else if (a_gnt) begin
      last_b_q <= 1'b0;
    end else if (b_gnt) begin
      last_b_q <= 1'b1;
    end
  end

  assign tie_pick_b = ~last_b_q;
`endif

  // Grants are only offered in IDLE with no pending clear; Reset masks them
  // so nothing can be accepted while the block is being reset.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!Reset && state_q == ST_IDLE && !Clear_Req) begin
      if (A_Req && B_Req) begin
        a_gnt = ~tie_pick_b;
        b_gnt = tie_pick_b;
      end else begin
        a_gnt = A_Req;
        b_gnt = B_Req;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_d  = 1'b0;
    dr_d    = dr_q;
    bus_d   = bus_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Clear_Req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else if (a_gnt) begin
          load_d = 1'b1;
          dr_d   = A_DR;
          bus_d  = A_Data;
        end else if (b_gnt) begin
          load_d = 1'b1;
          dr_d   = B_DR;
          bus_d  = B_Data;
        end
      end
      ST_CLEAR: begin
        load_d = 1'b1;
        dr_d   = cnt_q;
        bus_d  = '0;
        cnt_d  = cnt_q + ADDR_W'(1);
        // The edge that issues the last index also leaves CLEAR, so the
        // done pulse lines up with the DR=7 write.
        if (cnt_q == CNT_LAST) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      dr_q    <= '0;
      bus_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      dr_q    <= dr_d;
      bus_q   <= bus_d;
      done_q  <= done_d;
    end
  end

  assign A_Gnt      = a_gnt;
  assign B_Gnt      = b_gnt;
  assign Clear_Busy = (state_q == ST_CLEAR) && !Reset;
  assign Clear_Done = done_q;
  assign Load       = load_q;
  assign DR         = dr_q;
  assign Bus        = bus_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        A_Req = 1'b0;
  logic [2:0]  A_DR = '0;
  logic [15:0] A_Data = '0;
  logic        A_Gnt;
  logic        B_Req = 1'b0;
  logic [2:0]  B_DR = '0;
  logic [15:0] B_Data = '0;
  logic        B_Gnt;
  logic        Clear_Req = 1'b0;
  logic        Clear_Busy;
  logic        Clear_Done;
  logic        Load;
  logic [2:0]  DR;
  logic [15:0] Bus;

  int total = 0;
  int bad = 0;

  regfile_write_arbiter #(.DATA_W(16), .ADDR_W(3)) dut (
    .Clk(Clk), .Reset(Reset),
    .A_Req(A_Req), .A_DR(A_DR), .A_Data(A_Data), .A_Gnt(A_Gnt),
    .B_Req(B_Req), .B_DR(B_DR), .B_Data(B_Data), .B_Gnt(B_Gnt),
    .Clear_Req(Clear_Req), .Clear_Busy(Clear_Busy), .Clear_Done(Clear_Done),
    .Load(Load), .DR(DR), .Bus(Bus)
  );

  always #5 Clk = ~Clk;

  task automatic drop_inputs();
    A_Req = 1'b0; B_Req = 1'b0; Clear_Req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    drop_inputs();
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge Clk);
    Reset = 1'b1;
    A_Req = 1'b1; B_Req = 1'b1; A_DR = 3'd1; B_DR = 3'd2;
    #1;
    total++; if (A_Gnt !== 1'b0) begin bad++; $display("FAIL reset_a_gnt got=%b want=0", A_Gnt); end
    total++; if (B_Gnt !== 1'b0) begin bad++; $display("FAIL reset_b_gnt got=%b want=0", B_Gnt); end
    total++; if (Load !== 1'b0) begin bad++; $display("FAIL reset_load got=%b want=0", Load); end
    total++; if (DR !== 3'd0) begin bad++; $display("FAIL reset_dr got=%0d want=0", DR); end
    total++; if (Bus !== 16'h0) begin bad++; $display("FAIL reset_bus got=%h want=0000", Bus); end
    total++; if (Clear_Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", Clear_Busy); end
    total++; if (Clear_Done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", Clear_Done); end
    drop_inputs();
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_single_write();
    do_reset();
    A_Req = 1'b1; A_DR = 3'd3; A_Data = 16'hBEEF;
    #1;
    total++; if (A_Gnt !== 1'b1) begin bad++; $display("FAIL single_a_gnt got=%b want=1", A_Gnt); end
    @(negedge Clk);
    A_Req = 1'b0;
    total++; if (Load !== 1'b1 || DR !== 3'd3 || Bus !== 16'hBEEF) begin
      bad++; $display("FAIL single_write got load=%b dr=%0d bus=%h want load=1 dr=3 bus=beef", Load, DR, Bus);
    end
    @(negedge Clk);
    total++; if (Load !== 1'b0 || DR !== 3'd3 || Bus !== 16'hBEEF) begin
      bad++; $display("FAIL single_after got load=%b dr=%0d bus=%h want load=0 dr=3 bus=beef", Load, DR, Bus);
    end
  endtask

  task automatic test_round_robin();
    logic exp_b;
    do_reset();
    A_DR = 3'd1; A_Data = 16'h1111; B_DR = 3'd2; B_Data = 16'h2222;
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) begin
        exp_b = ((i - 1) % 2) == 1;
        total++; if (Load !== 1'b1 || DR !== (exp_b ? 3'd2 : 3'd1) || Bus !== (exp_b ? 16'h2222 : 16'h1111)) begin
          bad++; $display("FAIL rr_write%0d got load=%b dr=%0d bus=%h want b=%b", i - 1, Load, DR, Bus, exp_b);
        end
      end
      if (i == 4) begin
        drop_inputs();
      end else begin
        A_Req = 1'b1; B_Req = 1'b1;
        #1;
        exp_b = (i % 2) == 1;
        total++; if (A_Gnt !== !exp_b || B_Gnt !== exp_b) begin
          bad++; $display("FAIL rr_grant%0d got a=%b b=%b want a=%b b=%b", i, A_Gnt, B_Gnt, !exp_b, exp_b);
        end
        @(negedge Clk);
      end
    end
    @(negedge Clk);
    total++; if (Load !== 1'b0) begin bad++; $display("FAIL rr_idle got load=%b want=0", Load); end
  endtask

  task automatic test_clear_sweep();
    do_reset();
    Clear_Req = 1'b1;
    B_Req = 1'b1; B_DR = 3'd6; B_Data = 16'h6666;
    #1;
    total++; if (B_Gnt !== 1'b0) begin bad++; $display("FAIL clr_b_gnt_start got=%b want=0", B_Gnt); end
    @(negedge Clk);
    Clear_Req = 1'b0;
    #1;
    total++; if (Clear_Busy !== 1'b1 || Load !== 1'b0 || B_Gnt !== 1'b0) begin
      bad++; $display("FAIL clr_enter got busy=%b load=%b bgnt=%b want 1 0 0", Clear_Busy, Load, B_Gnt);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge Clk);
      #1;
      total++; if (Load !== 1'b1 || DR !== 3'(k) || Bus !== 16'h0) begin
        bad++; $display("FAIL clr_write%0d got load=%b dr=%0d bus=%h want load=1 dr=%0d bus=0000", k, Load, DR, Bus, k);
      end
      total++; if (Clear_Done !== (k == 7) || Clear_Busy !== (k != 7) || B_Gnt !== (k == 7)) begin
        bad++; $display("FAIL clr_flags%0d got done=%b busy=%b bgnt=%b", k, Clear_Done, Clear_Busy, B_Gnt);
      end
    end
    @(negedge Clk);
    B_Req = 1'b0;
    total++; if (Load !== 1'b1 || DR !== 3'd6 || Bus !== 16'h6666 || Clear_Done !== 1'b0) begin
      bad++; $display("FAIL clr_b_served got load=%b dr=%0d bus=%h done=%b want 1 6 6666 0", Load, DR, Bus, Clear_Done);
    end
  endtask

  task automatic test_clear_beats_a();
    do_reset();
    Clear_Req = 1'b1;
    A_Req = 1'b1; A_DR = 3'd2; A_Data = 16'h0A0A;
    #1;
    total++; if (A_Gnt !== 1'b0) begin bad++; $display("FAIL cba_first got a_gnt=%b want=0", A_Gnt); end
    @(negedge Clk);
    Clear_Req = 1'b0;
    for (int j = 0; j <= 8; j++) begin
      #1;
      total++; if (A_Gnt !== (j == 8)) begin
        bad++; $display("FAIL cba_gnt%0d got a_gnt=%b want=%b", j, A_Gnt, (j == 8));
      end
      @(negedge Clk);
    end
    A_Req = 1'b0;
    total++; if (Load !== 1'b1 || DR !== 3'd2 || Bus !== 16'h0A0A) begin
      bad++; $display("FAIL cba_write got load=%b dr=%0d bus=%h want 1 2 0a0a", Load, DR, Bus);
    end
  endtask

  task automatic test_reset_mid_sweep();
    bit found = 0;
    do_reset();
    Clear_Req = 1'b1;
    @(negedge Clk);
    Clear_Req = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge Clk);
      if (Load === 1'b1 && DR === 3'd4) found = 1;
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL rms_wait got no DR=4 write within 20 cycles want DR=4");
    end else begin
      total++; if (Clear_Busy !== 1'b1) begin bad++; $display("FAIL rms_busy_pre got=%b want=1", Clear_Busy); end
      Reset = 1'b1;
      #1;
      total++; if (Load !== 1'b0 || Clear_Busy !== 1'b0 || Clear_Done !== 1'b0 || DR !== 3'd0) begin
        bad++; $display("FAIL rms_abort got load=%b busy=%b done=%b dr=%0d want 0 0 0 0", Load, Clear_Busy, Clear_Done, DR);
      end
      @(negedge Clk);
      Reset = 1'b0;
      A_Req = 1'b1; A_DR = 3'd5; A_Data = 16'h0055;
      #1;
      total++; if (A_Gnt !== 1'b1) begin bad++; $display("FAIL rms_a_gnt got=%b want=1", A_Gnt); end
      @(negedge Clk);
      A_Req = 1'b0;
      total++; if (Load !== 1'b1 || DR !== 3'd5 || Bus !== 16'h0055) begin
        bad++; $display("FAIL rms_write got load=%b dr=%0d bus=%h want 1 5 0055", Load, DR, Bus);
      end
      @(negedge Clk);
      total++; if (Load !== 1'b0) begin bad++; $display("FAIL rms_after got load=%b want=0", Load); end
    end
  endtask

`ifdef REGARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    do_reset();
    A_DR = 3'd1; A_Data = 16'h1111; B_DR = 3'd2; B_Data = 16'h2222;
    A_Req = 1'b1; B_Req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (A_Gnt !== 1'b1 || B_Gnt !== 1'b0) begin
        bad++; $display("FAIL fp_grant%0d got a=%b b=%b want a=1 b=0", i, A_Gnt, B_Gnt);
      end
      @(negedge Clk);
    end
    A_Req = 1'b0;
    #1;
    total++; if (B_Gnt !== 1'b1) begin bad++; $display("FAIL fp_b_after got=%b want=1", B_Gnt); end
    @(negedge Clk);
    B_Req = 1'b0;
    total++; if (Load !== 1'b1 || DR !== 3'd2 || Bus !== 16'h2222) begin
      bad++; $display("FAIL fp_b_write got load=%b dr=%0d bus=%h want 1 2 2222", Load, DR, Bus);
    end
  endtask
`endif

  // Reference model: a sweep is "8 zero writes to R0..R7 in order", the
  // arbiter picks the sole requester or, on a tie, whoever was not served last
  // (A always, in the fixed-priority build). Expected port outputs are the
  // write chosen at the previous edge.
  task automatic test_random();
    bit          a_pend = 0, b_pend = 0;
    bit          sweeping = 0;
    int          sweep_pos = 0;
    int          last_who = 2;
    int          g;
    bit          e_load = 0, e_done = 0;
    logic [2:0]  e_dr = '0;
    logic [15:0] e_bus = '0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c > 0) @(negedge Clk);
      total++; if (Load !== e_load || DR !== e_dr || Bus !== e_bus) begin
        bad++; $display("FAIL rnd_port c=%0d got load=%b dr=%0d bus=%h want load=%b dr=%0d bus=%h", c, Load, DR, Bus, e_load, e_dr, e_bus);
      end
      total++; if (Clear_Done !== e_done || Clear_Busy !== sweeping) begin
        bad++; $display("FAIL rnd_flags c=%0d got done=%b busy=%b want done=%b busy=%b", c, Clear_Done, Clear_Busy, e_done, sweeping);
      end
      if (!a_pend && $urandom_range(0, 9) < 4) begin
        a_pend = 1; A_DR = 3'($urandom); A_Data = 16'($urandom);
      end
      if (!b_pend && $urandom_range(0, 9) < 4) begin
        b_pend = 1; B_DR = 3'($urandom); B_Data = 16'($urandom);
      end
      A_Req = a_pend; B_Req = b_pend;
      Clear_Req = ($urandom_range(0, 29) == 0);
      #1;
      g = 0;
      if (!sweeping && !Clear_Req) begin
        if (a_pend && b_pend) begin
`ifdef REGARB_FIXED_PRIO_EN
          g = 1;
`else
          g = (last_who == 1) ? 2 : 1;
`endif
        end else if (a_pend) g = 1;
        else if (b_pend) g = 2;
      end
      total++; if (A_Gnt !== (g == 1) || B_Gnt !== (g == 2)) begin
        bad++; $display("FAIL rnd_grant c=%0d got a=%b b=%b want who=%0d", c, A_Gnt, B_Gnt, g);
      end
      e_done = 0;
      if (sweeping) begin
        e_load = 1; e_dr = 3'(sweep_pos); e_bus = '0;
        e_done = (sweep_pos == 7);
        sweep_pos++;
        if (sweep_pos == 8) sweeping = 0;
      end else if (Clear_Req) begin
        sweeping = 1; sweep_pos = 0; e_load = 0;
      end else if (g == 1) begin
        e_load = 1; e_dr = A_DR; e_bus = A_Data; a_pend = 0; last_who = 1;
      end else if (g == 2) begin
        e_load = 1; e_dr = B_DR; e_bus = B_Data; b_pend = 0; last_who = 2;
      end else begin
        e_load = 0;
      end
    end
    @(negedge Clk);
    drop_inputs();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_clear_sweep();
    test_clear_beats_a();
    test_reset_mid_sweep();
`ifdef REGARB_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
